// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared definitions for the pipe_issue_ctrl issue controller: field widths, func codes,
// bubble encoding and the packed instruction / scoreboard layouts.
package pipe_issue_ctrl_pkg;

   localparam int unsigned REG_W   = 4;
   localparam int unsigned FUNC_W  = 4;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned ICNT_W  = 16;

   localparam logic [FUNC_W-1:0] FN_ADD   = 4'd0;
   localparam logic [FUNC_W-1:0] FN_SUB   = 4'd1;
   localparam logic [FUNC_W-1:0] FN_MUL   = 4'd2;
   localparam logic [FUNC_W-1:0] FN_PASSA = 4'd3;
   localparam logic [FUNC_W-1:0] FN_PASSB = 4'd4;
   localparam logic [FUNC_W-1:0] FN_AND   = 4'd5;
   localparam logic [FUNC_W-1:0] FN_OR    = 4'd6;
   localparam logic [FUNC_W-1:0] FN_XOR   = 4'd7;
   localparam logic [FUNC_W-1:0] FN_NOT   = 4'd8;
   localparam logic [FUNC_W-1:0] FN_INC   = 4'd9;
   localparam logic [FUNC_W-1:0] FN_SHR   = 4'd10;
   localparam logic [FUNC_W-1:0] FN_SHL   = 4'd11;
   localparam logic [FUNC_W-1:0] MAX_FUNC = FN_SHL;

   localparam logic [REG_W-1:0]  NOP_RD   = 4'd15;
   localparam logic [ADDR_W-1:0] NOP_ADDR = 8'd255;
   localparam logic [FUNC_W-1:0] NOP_FUNC = FN_PASSA;

   // 24-bit instruction word {rs1,rs2,rd,func,addr}
   typedef struct packed {
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic [FUNC_W-1:0] func;
      logic [ADDR_W-1:0] addr;
   } instr_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
   } sb_entry_t;

   localparam instr_t NOP_INSTR = '{rs1: 4'd0, rs2: 4'd0, rd: NOP_RD, func: NOP_FUNC, addr: NOP_ADDR};

   // The bubble register is reserved, so it can never be a real destination.
   function automatic logic is_legal(input instr_t ins);
      return (ins.func <= MAX_FUNC) && (ins.rd != NOP_RD);
   endfunction

endpackage

// File: rtl/pipe_issue_ctrl_instr_fifo.sv
// Synchronous instruction FIFO with combinational head read; push and pop may coincide.
module pipe_issue_ctrl_instr_fifo
   import pipe_issue_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  instr_t                 push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output instr_t                 head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   instr_t             mem_q [DEPTH];
   instr_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_ok_c, pop_ok_c;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head      = mem_q[rd_ptr_q];
   assign push_ok_c = push && !full;
   assign pop_ok_c  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_c) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_c, pop_ok_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is readable.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller: buffers instructions, interlocks RAW hazards against recently issued
// destinations, fills stalls with NOP bubbles and delays func by one cycle for the ALU stage.
module pipe_issue_ctrl
   import pipe_issue_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned HAZ_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [REG_W-1:0]       in_rs1,
   input  logic [REG_W-1:0]       in_rs2,
   input  logic [REG_W-1:0]       in_rd,
   input  logic [FUNC_W-1:0]      in_func,
   input  logic [ADDR_W-1:0]      in_addr,
   output logic [REG_W-1:0]       iss_rs1,
   output logic [REG_W-1:0]       iss_rs2,
   output logic [REG_W-1:0]       iss_rd,
   output logic [ADDR_W-1:0]      iss_addr,
   output logic [FUNC_W-1:0]      iss_func,
   output logic                   iss_valid,
   output logic                   stall,
   output logic                   illegal,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [ICNT_W-1:0]      issue_cnt
);

   instr_t              in_instr_c, head_c;
   logic                fifo_full_c, fifo_empty_c;
   logic                accept_c, legal_c, push_c, pop_c, hazard_c;

   instr_t              iss_q, iss_d;
   logic                iss_valid_q, iss_valid_d;
   logic                stall_q, stall_d;
   logic                illegal_q, illegal_d;
   logic [FUNC_W-1:0]   func_skew_q, func_skew_d;
   logic [ICNT_W-1:0]   issue_cnt_q, issue_cnt_d;
   sb_entry_t           sb_q [HAZ_DEPTH];
   sb_entry_t           sb_d [HAZ_DEPTH];

   assign in_instr_c = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
   assign in_ready   = !fifo_full_c;
   assign accept_c   = in_valid && in_ready;
   assign legal_c    = is_legal(in_instr_c);
   assign push_c     = accept_c && legal_c;
   assign pop_c      = !fifo_empty_c && !hazard_c;

   pipe_issue_ctrl_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (in_instr_c),
      .pop       (pop_c),
      .full      (fifo_full_c),
      .empty     (fifo_empty_c),
      .count     (fifo_count),
      .head      (head_c)
   );

   // Head may not read any destination still in flight towards the regbank.
   always_comb begin
      hazard_c = 1'b0;
      for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
         if (sb_q[i].valid && ((head_c.rs1 == sb_q[i].rd) || (head_c.rs2 == sb_q[i].rd))) begin
            hazard_c = 1'b1;
         end
      end
   end

   always_comb begin
      iss_d       = NOP_INSTR;
      iss_valid_d = 1'b0;
      stall_d     = !fifo_empty_c && hazard_c;
      illegal_d   = accept_c && !legal_c;
      func_skew_d = iss_q.func;
      issue_cnt_d = issue_cnt_q;
      sb_d        = sb_q;
      if (pop_c) begin
         iss_d       = head_c;
         iss_valid_d = 1'b1;
         issue_cnt_d = issue_cnt_q + ICNT_W'(1);
      end
      sb_d[0] = '{valid: pop_c, rd: head_c.rd};
      for (int unsigned i = 1; i < HAZ_DEPTH; i++) begin
         sb_d[i] = sb_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         iss_q       <= NOP_INSTR;
         iss_valid_q <= 1'b0;
         stall_q     <= 1'b0;
         illegal_q   <= 1'b0;
         func_skew_q <= NOP_FUNC;
         issue_cnt_q <= '0;
         sb_q        <= '{default: '0};
      end else begin
         iss_q       <= iss_d;
         iss_valid_q <= iss_valid_d;
         stall_q     <= stall_d;
         illegal_q   <= illegal_d;
         func_skew_q <= func_skew_d;
         issue_cnt_q <= issue_cnt_d;
         sb_q        <= sb_d;
      end
   end

   assign iss_rs1   = iss_q.rs1;
   assign iss_rs2   = iss_q.rs2;
   assign iss_rd    = iss_q.rd;
   assign iss_addr  = iss_q.addr;
   assign iss_func  = func_skew_q;
   assign iss_valid = iss_valid_q;
   assign stall     = stall_q;
   assign illegal   = illegal_q;
   assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: hand-derived per-cycle vector table, then random traffic
// against a queue-and-ready-time reference model.
`timescale 1ns/1ps
module tb_pipe_issue_ctrl;
   import pipe_issue_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready;
   logic [3:0]  in_rs1, in_rs2, in_rd, in_func;
   logic [7:0]  in_addr;
   logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
   logic [7:0]  iss_addr;
   logic        iss_valid, stall, illegal;
   logic [2:0]  fifo_count;
   logic [15:0] issue_cnt;

   always #5 clk = ~clk;

   pipe_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_addr(iss_addr),
      .iss_func(iss_func), .iss_valid(iss_valid), .stall(stall), .illegal(illegal),
      .fifo_count(fifo_count), .issue_cnt(issue_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: FIFO as a queue, each register readable from issue cycle (producer + 3).
   instr_t      m_q[$];
   int          m_ready_at[16];
   int          m_cyc = 0;
   instr_t      m_iss;
   logic        m_valid, m_stall, m_ill;
   logic [3:0]  m_func;
   logic [15:0] m_cnt;
   bit          cmp_model = 1'b0;

   function automatic instr_t mk(input int rs1, input int rs2, input int rd, input int func, input int addr);
      instr_t i;
      i.rs1  = 4'(rs1);
      i.rs2  = 4'(rs2);
      i.rd   = 4'(rd);
      i.func = 4'(func);
      i.addr = 8'(addr);
      return i;
   endfunction

   task automatic model_step(input logic rst, input logic vld, input instr_t ins);
      logic   acc, iss, st;
      instr_t h;
      h = mk(0, 0, 15, 3, 255);
      if (!rst) begin
         m_q.delete();
         foreach (m_ready_at[r]) m_ready_at[r] = 0;
         m_iss   = mk(0, 0, 15, 3, 255);
         m_valid = 1'b0;
         m_stall = 1'b0;
         m_ill   = 1'b0;
         m_func  = 4'd3;
         m_cnt   = 16'd0;
      end else begin
         acc = vld && (m_q.size() < 4);
         iss = 1'b0;
         st  = 1'b0;
         if (m_q.size() > 0) begin
            h = m_q[0];
            if (m_cyc >= m_ready_at[h.rs1] && m_cyc >= m_ready_at[h.rs2]) iss = 1'b1;
            else st = 1'b1;
         end
         m_func = m_iss.func;
         if (iss) begin
            void'(m_q.pop_front());
            m_ready_at[h.rd] = m_cyc + 3;
            m_iss = h;
            m_cnt = m_cnt + 16'd1;
         end else begin
            m_iss = mk(0, 0, 15, 3, 255);
         end
         m_valid = iss;
         m_stall = st;
         m_ill   = acc && (ins.func > 4'd11 || ins.rd == 4'd15);
         if (acc && !m_ill) m_q.push_back(ins);
      end
      m_cyc++;
   endtask

   task automatic drive(input logic rst, input logic vld, input instr_t ins);
      rst_n    = rst;
      in_valid = vld;
      in_rs1   = ins.rs1;
      in_rs2   = ins.rs2;
      in_rd    = ins.rd;
      in_func  = ins.func;
      in_addr  = ins.addr;
      @(posedge clk);
      #1;
      model_step(rst, vld, ins);
      if (cmp_model) begin
         chk("m_rs1",   32'(iss_rs1),    32'(m_iss.rs1));
         chk("m_rs2",   32'(iss_rs2),    32'(m_iss.rs2));
         chk("m_rd",    32'(iss_rd),     32'(m_iss.rd));
         chk("m_addr",  32'(iss_addr),   32'(m_iss.addr));
         chk("m_func",  32'(iss_func),   32'(m_func));
         chk("m_valid", 32'(iss_valid),  32'(m_valid));
         chk("m_stall", 32'(stall),      32'(m_stall));
         chk("m_ill",   32'(illegal),    32'(m_ill));
         chk("m_count", 32'(fifo_count), 32'(m_q.size()));
         chk("m_icnt",  32'(issue_cnt),  32'(m_cnt));
         chk("m_ready", 32'(in_ready),   32'(m_q.size() < 4));
      end
   endtask

   typedef struct {
      logic       rst;
      logic       vld;
      instr_t     ins;
      logic       e_valid;
      logic [3:0] e_rd;
      logic [7:0] e_addr;
      logic [3:0] e_func;
      logic       e_stall;
      logic       e_ill;
      int         e_cnt;
      logic       e_rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic void addv(input logic rst, input logic vld, input instr_t ins,
                                input logic ev, input int erd, input int eaddr, input int efunc,
                                input logic est, input logic eill, input int ecnt, input logic erdy);
      vec_t v;
      v.rst = rst; v.vld = vld; v.ins = ins;
      v.e_valid = ev; v.e_rd = 4'(erd); v.e_addr = 8'(eaddr); v.e_func = 4'(efunc);
      v.e_stall = est; v.e_ill = eill; v.e_cnt = ecnt; v.e_rdy = erdy;
      vecs.push_back(v);
   endfunction

   initial begin
      instr_t idle;
      int     exp_ic;
      idle = mk(0, 0, 0, 0, 0);

      // reset
      addv(0, 0, idle,                   0, 15, 255, 3, 0, 0, 0, 1);
      addv(0, 0, idle,                   0, 15, 255, 3, 0, 0, 0, 1);
      // independent pair issues back to back
      addv(1, 1, mk(6, 4, 10, 0, 125),   0, 15, 255, 3, 0, 0, 1, 1);
      addv(1, 1, mk(7, 8, 11, 2, 126),   1, 10, 125, 3, 0, 0, 1, 1);
      addv(1, 0, idle,                   1, 11, 126, 0, 0, 0, 0, 1);
      addv(1, 0, idle,                   0, 15, 255, 2, 0, 0, 0, 1);
      addv(1, 0, idle,                   0, 15, 255, 3, 0, 0, 0, 1);
      // RAW: consumer issues 3 cycles after producer, 2 stall cycles
      addv(1, 1, mk(6, 4, 10, 0, 20),    0, 15, 255, 3, 0, 0, 1, 1);
      addv(1, 1, mk(10, 1, 12, 0, 21),   1, 10, 20,  3, 0, 0, 1, 1);
      addv(1, 0, idle,                   0, 15, 255, 0, 1, 0, 1, 1);
      addv(1, 0, idle,                   0, 15, 255, 3, 1, 0, 1, 1);
      addv(1, 0, idle,                   1, 12, 21,  3, 0, 0, 0, 1);
      addv(1, 0, idle,                   0, 15, 255, 0, 0, 0, 0, 1);
      // illegal func, then illegal rd
      addv(1, 1, mk(0, 0, 3, 12, 1),     0, 15, 255, 3, 0, 1, 0, 1);
      addv(1, 1, mk(0, 0, 15, 1, 2),     0, 15, 255, 3, 0, 1, 0, 1);
      addv(1, 0, idle,                   0, 15, 255, 3, 0, 0, 0, 1);
      // dependent chain on r2 fills the FIFO
      addv(1, 1, mk(2, 0, 2, 0, 40),     0, 15, 255, 3, 0, 0, 1, 1);
      addv(1, 1, mk(2, 0, 2, 0, 41),     1, 2,  40,  3, 0, 0, 1, 1);
      addv(1, 1, mk(2, 0, 2, 0, 42),     0, 15, 255, 0, 1, 0, 2, 1);
      addv(1, 1, mk(2, 0, 2, 0, 43),     0, 15, 255, 3, 1, 0, 3, 1);
      addv(1, 1, mk(2, 0, 2, 0, 44),     1, 2,  41,  3, 0, 0, 3, 1);
      addv(1, 1, mk(2, 0, 2, 0, 45),     0, 15, 255, 0, 1, 0, 4, 0);
      addv(1, 1, mk(2, 0, 2, 0, 46),     0, 15, 255, 3, 1, 0, 4, 0);
      addv(1, 0, idle,                   1, 2,  42,  3, 0, 0, 3, 1);
      addv(1, 0, idle,                   0, 15, 255, 0, 1, 0, 3, 1);
      addv(1, 0, idle,                   0, 15, 255, 3, 1, 0, 3, 1);
      addv(1, 0, idle,                   1, 2,  43,  3, 0, 0, 2, 1);
      addv(1, 0, idle,                   0, 15, 255, 0, 1, 0, 2, 1);
      addv(1, 0, idle,                   0, 15, 255, 3, 1, 0, 2, 1);
      addv(1, 0, idle,                   1, 2,  44,  3, 0, 0, 1, 1);
      addv(1, 0, idle,                   0, 15, 255, 0, 1, 0, 1, 1);
      addv(1, 0, idle,                   0, 15, 255, 3, 1, 0, 1, 1);
      addv(1, 0, idle,                   1, 2,  45,  3, 0, 0, 0, 1);
      addv(1, 0, idle,                   0, 15, 255, 0, 0, 0, 0, 1);
      // three entries queued behind a stall, then mid-run reset
      addv(1, 1, mk(0, 0, 4, 1, 59),     0, 15, 255, 3, 0, 0, 1, 1);
      addv(1, 1, mk(4, 0, 5, 1, 60),     1, 4,  59,  3, 0, 0, 1, 1);
      addv(1, 1, mk(5, 0, 6, 1, 61),     0, 15, 255, 1, 1, 0, 2, 1);
      addv(1, 1, mk(0, 0, 7, 1, 62),     0, 15, 255, 3, 1, 0, 3, 1);
      addv(1, 1, mk(0, 0, 8, 1, 63),     1, 5,  60,  3, 0, 0, 3, 1);
      addv(0, 1, mk(0, 0, 9, 1, 65),     0, 15, 255, 3, 0, 0, 0, 1);
      addv(1, 1, mk(5, 6, 9, 2, 64),     0, 15, 255, 3, 0, 0, 1, 1);
      addv(1, 0, idle,                   1, 9,  64,  3, 0, 0, 0, 1);
      addv(1, 0, idle,                   0, 15, 255, 2, 0, 0, 0, 1);

      exp_ic = 0;
      foreach (vecs[k]) begin
         drive(vecs[k].rst, vecs[k].vld, vecs[k].ins);
         if (!vecs[k].rst) exp_ic = 0;
         else if (vecs[k].e_valid) exp_ic++;
         chk($sformatf("v%0d_valid", k), 32'(iss_valid),  32'(vecs[k].e_valid));
         chk($sformatf("v%0d_rd", k),    32'(iss_rd),     32'(vecs[k].e_rd));
         chk($sformatf("v%0d_addr", k),  32'(iss_addr),   32'(vecs[k].e_addr));
         chk($sformatf("v%0d_func", k),  32'(iss_func),   32'(vecs[k].e_func));
         chk($sformatf("v%0d_stall", k), 32'(stall),      32'(vecs[k].e_stall));
         chk($sformatf("v%0d_ill", k),   32'(illegal),    32'(vecs[k].e_ill));
         chk($sformatf("v%0d_count", k), 32'(fifo_count), 32'(vecs[k].e_cnt));
         chk($sformatf("v%0d_ready", k), 32'(in_ready),   32'(vecs[k].e_rdy));
         chk($sformatf("v%0d_icnt", k),  32'(issue_cnt),  32'(exp_ic));
      end

      // random traffic with narrow register range to provoke hazards and backpressure
      cmp_model = 1'b1;
      drive(1'b0, 1'b0, idle);
      drive(1'b0, 1'b0, idle);
      for (int n = 0; n < 1500; n++) begin
         instr_t r;
         logic   rr, vv;
         rr = ($urandom_range(0, 199) != 0);
         vv = ($urandom_range(0, 3) != 0);
         r  = mk($urandom_range(0, 4), $urandom_range(0, 4),
                 ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 4),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11),
                 $urandom_range(0, 255));
         drive(rr, vv, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
